// File: rtl/vdmem_arb_pkg.sv
// vdmem_arb_pkg: shared DMEM interface types, bus widths, and arbiter IDs and states
package vdmem_arb_pkg;
   localparam int SCR1_DMEM_AWIDTH = 32;
   localparam int SCR1_DMEM_DWIDTH = 32;
   typedef enum logic {
      SCR1_MEM_CMD_RD,
      SCR1_MEM_CMD_WR
   } type_scr1_mem_cmd_e;
   typedef enum logic [1:0] {
      SCR1_MEM_WIDTH_BYTE,
      SCR1_MEM_WIDTH_HWORD,
      SCR1_MEM_WIDTH_WORD,
      SCR1_MEM_WIDTH_ERROR
   } type_scr1_mem_width_e;
   typedef enum logic [1:0] {
      SCR1_MEM_RESP_NOTRDY,
      SCR1_MEM_RESP_RDY_OK,
      SCR1_MEM_RESP_RDY_ER
   } type_scr1_mem_resp_e;
   typedef enum logic {
      SCR1_ARB_ID_LSU,
      SCR1_ARB_ID_VEXU
   } type_scr1_arb_id_e;
   typedef enum logic {
      SCR1_ARB_FSM_IDLE,
      SCR1_ARB_FSM_WAIT_RESP
   } type_scr1_arb_fsm_e;
endpackage

// File: rtl/vdmem_arb.sv
// vdmem_arb: two-master (scalar LSU, VEXU) arbiter onto one DMEM port, one transaction in flight
// Ports: clk/rst_n (async active-low); lsu2arb_*/arb2lsu_* and vexu2arb_*/arb2vexu_* are the
// requester sides; arb2dmem_*/dmem2arb_* is the shared DMEM side.
module vdmem_arb
   import vdmem_arb_pkg::*;
#(
   parameter bit VEXU_FIRST = 1'b0
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        lsu2arb_req,
   input  type_scr1_mem_cmd_e          lsu2arb_cmd,
   input  type_scr1_mem_width_e        lsu2arb_width,
   input  logic [SCR1_DMEM_AWIDTH-1:0] lsu2arb_addr,
   input  logic [SCR1_DMEM_DWIDTH-1:0] lsu2arb_wdata,
   output logic                        arb2lsu_req_ack,
   output logic [SCR1_DMEM_DWIDTH-1:0] arb2lsu_rdata,
   output type_scr1_mem_resp_e         arb2lsu_resp,
   input  logic                        vexu2arb_req,
   input  type_scr1_mem_cmd_e          vexu2arb_cmd,
   input  type_scr1_mem_width_e        vexu2arb_width,
   input  logic [SCR1_DMEM_AWIDTH-1:0] vexu2arb_addr,
   input  logic [SCR1_DMEM_DWIDTH-1:0] vexu2arb_wdata,
   output logic                        arb2vexu_req_ack,
   output logic [SCR1_DMEM_DWIDTH-1:0] arb2vexu_rdata,
   output type_scr1_mem_resp_e         arb2vexu_resp,
   output logic                        arb2dmem_req,
   output type_scr1_mem_cmd_e          arb2dmem_cmd,
   output type_scr1_mem_width_e        arb2dmem_width,
   output logic [SCR1_DMEM_AWIDTH-1:0] arb2dmem_addr,
   output logic [SCR1_DMEM_DWIDTH-1:0] arb2dmem_wdata,
   input  logic                        dmem2arb_req_ack,
   input  logic [SCR1_DMEM_DWIDTH-1:0] dmem2arb_rdata,
   input  type_scr1_mem_resp_e         dmem2arb_resp
);
   localparam type_scr1_arb_id_e RST_PRIO = VEXU_FIRST ? SCR1_ARB_ID_VEXU : SCR1_ARB_ID_LSU;
   type_scr1_arb_fsm_e state_q, state_d;
   type_scr1_arb_id_e  owner_q, owner_d, lock_id_q, lock_id_d, rr_prio_q, rr_prio_d, grant;
   logic               lock_vld_q, lock_vld_d, lock_hit, gnt_lsu, idle, wait_st, own_lsu, dmem_hs, resp_done;
   // rst_n gates the request side so that outputs sit at reset values while reset is held
   assign idle      = rst_n & (state_q == SCR1_ARB_FSM_IDLE);
   assign wait_st   = state_q == SCR1_ARB_FSM_WAIT_RESP;
   assign gnt_lsu   = grant == SCR1_ARB_ID_LSU;
   assign own_lsu   = owner_q == SCR1_ARB_ID_LSU;
   assign dmem_hs   = arb2dmem_req & dmem2arb_req_ack;
   assign resp_done = wait_st & ((dmem2arb_resp == SCR1_MEM_RESP_RDY_OK) | (dmem2arb_resp == SCR1_MEM_RESP_RDY_ER));
   assign arb2dmem_req     = idle & (gnt_lsu ? lsu2arb_req : vexu2arb_req);
   assign arb2dmem_cmd     = idle ? (gnt_lsu ? lsu2arb_cmd : vexu2arb_cmd) : SCR1_MEM_CMD_RD;
   assign arb2dmem_width   = idle ? (gnt_lsu ? lsu2arb_width : vexu2arb_width) : SCR1_MEM_WIDTH_BYTE;
   assign arb2dmem_addr    = idle ? (gnt_lsu ? lsu2arb_addr : vexu2arb_addr) : '0;
   assign arb2dmem_wdata   = idle ? (gnt_lsu ? lsu2arb_wdata : vexu2arb_wdata) : '0;
   assign arb2lsu_req_ack  = idle & gnt_lsu & dmem2arb_req_ack;
   assign arb2vexu_req_ack = idle & ~gnt_lsu & dmem2arb_req_ack;
   assign arb2lsu_resp     = (wait_st & own_lsu) ? dmem2arb_resp : SCR1_MEM_RESP_NOTRDY;
   assign arb2vexu_resp    = (wait_st & ~own_lsu) ? dmem2arb_resp : SCR1_MEM_RESP_NOTRDY;
   assign arb2lsu_rdata    = (wait_st & own_lsu) ? dmem2arb_rdata : '0;
   assign arb2vexu_rdata   = (wait_st & ~own_lsu) ? dmem2arb_rdata : '0;
   always_comb begin
      // a stalled grantee keeps the grant while it holds req, so its request fields never change mid-handshake
      lock_hit   = lock_vld_q & ((lock_id_q == SCR1_ARB_ID_LSU) ? lsu2arb_req : vexu2arb_req);
      grant      = lock_hit ? lock_id_q :
                   (lsu2arb_req ^ vexu2arb_req) ? (lsu2arb_req ? SCR1_ARB_ID_LSU : SCR1_ARB_ID_VEXU) :
                   rr_prio_q;
      state_d    = dmem_hs ? SCR1_ARB_FSM_WAIT_RESP : resp_done ? SCR1_ARB_FSM_IDLE : state_q;
      owner_d    = dmem_hs ? grant : owner_q;
      lock_vld_d = arb2dmem_req & ~dmem2arb_req_ack;
      lock_id_d  = lock_vld_d ? grant : lock_id_q;
      rr_prio_d  = resp_done ? (own_lsu ? SCR1_ARB_ID_VEXU : SCR1_ARB_ID_LSU) : rr_prio_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= SCR1_ARB_FSM_IDLE;
         owner_q    <= SCR1_ARB_ID_LSU;
         lock_vld_q <= 1'b0;
         lock_id_q  <= SCR1_ARB_ID_LSU;
         rr_prio_q  <= RST_PRIO;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         lock_vld_q <= lock_vld_d;
         lock_id_q  <= lock_id_d;
         rr_prio_q  <= rr_prio_d;
      end
   end
endmodule

// File: tb/tb_vdmem_arb.sv
// tb_vdmem_arb: directed scoreboard bench for vdmem_arb with a small DMEM responder
module tb_vdmem_arb;
   import vdmem_arb_pkg::*;
   typedef struct {
      type_scr1_arb_id_e   id;
      bit                  is_resp;
      logic [31:0]         val;
      type_scr1_mem_resp_e resp;
      bit                  b2b;
   } exp_t;
   logic clk = 0, rst_n = 0;
   logic lsu2arb_req, vexu2arb_req, arb2lsu_req_ack, arb2vexu_req_ack, arb2dmem_req, dmem2arb_req_ack;
   type_scr1_mem_cmd_e   lsu2arb_cmd, vexu2arb_cmd, arb2dmem_cmd;
   type_scr1_mem_width_e lsu2arb_width, vexu2arb_width, arb2dmem_width;
   logic [31:0] lsu2arb_addr, lsu2arb_wdata, vexu2arb_addr, vexu2arb_wdata, arb2dmem_addr, arb2dmem_wdata;
   logic [31:0] arb2lsu_rdata, arb2vexu_rdata, dmem2arb_rdata;
   type_scr1_mem_resp_e arb2lsu_resp, arb2vexu_resp, dmem2arb_resp;
   exp_t exp_q[$];
   int checks = 0, failures = 0, cyc = 0, last_resp_cyc = -10, lat = 1, ack_from = 0, cnt = 0;
   logic pend = 0;
   logic [31:0] cap_addr = '0;
   vdmem_arb #(.VEXU_FIRST(1'b0)) dut (
      .clk(clk), .rst_n(rst_n),
      .lsu2arb_req(lsu2arb_req), .lsu2arb_cmd(lsu2arb_cmd), .lsu2arb_width(lsu2arb_width),
      .lsu2arb_addr(lsu2arb_addr), .lsu2arb_wdata(lsu2arb_wdata),
      .arb2lsu_req_ack(arb2lsu_req_ack), .arb2lsu_rdata(arb2lsu_rdata), .arb2lsu_resp(arb2lsu_resp),
      .vexu2arb_req(vexu2arb_req), .vexu2arb_cmd(vexu2arb_cmd), .vexu2arb_width(vexu2arb_width),
      .vexu2arb_addr(vexu2arb_addr), .vexu2arb_wdata(vexu2arb_wdata),
      .arb2vexu_req_ack(arb2vexu_req_ack), .arb2vexu_rdata(arb2vexu_rdata), .arb2vexu_resp(arb2vexu_resp),
      .arb2dmem_req(arb2dmem_req), .arb2dmem_cmd(arb2dmem_cmd), .arb2dmem_width(arb2dmem_width),
      .arb2dmem_addr(arb2dmem_addr), .arb2dmem_wdata(arb2dmem_wdata),
      .dmem2arb_req_ack(dmem2arb_req_ack), .dmem2arb_rdata(dmem2arb_rdata), .dmem2arb_resp(dmem2arb_resp)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   // DMEM responder: acks once cyc reaches ack_from, answers lat cycles after the ack;
   // 0x204 answers RDY_ER, 0x100 returns DEADBEEF, other addresses return ~addr
   always_comb begin
      dmem2arb_req_ack = arb2dmem_req && (cyc >= ack_from);
      dmem2arb_resp    = (pend && cnt == 0) ? ((cap_addr == 32'h204) ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK) : SCR1_MEM_RESP_NOTRDY;
      dmem2arb_rdata   = (pend && cnt == 0) ? ((cap_addr == 32'h100) ? 32'hDEADBEEF : ~cap_addr) : '0;
   end
   always @(posedge clk) begin
      if (arb2dmem_req && dmem2arb_req_ack) begin
         pend     <= 1'b1;
         cnt      <= lat;
         cap_addr <= arb2dmem_addr;
      end else if (pend) begin
         if (cnt == 0) pend <= 1'b0;
         else cnt <= cnt - 1;
      end
   end
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, expv);
      end
   endtask
   task automatic check_ev(input type_scr1_arb_id_e id, input bit is_resp, input logic [31:0] val, input type_scr1_mem_resp_e resp);
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL unexpected_event: id=%0d resp_ev=%0d val=%0h resp=%0d with empty scoreboard", id, is_resp, val, resp);
         return;
      end
      e = exp_q.pop_front();
      if (e.id != id || e.is_resp != is_resp || e.val != val || (is_resp && e.resp != resp) ||
          (!is_resp && arb2dmem_wdata != (val ^ 32'h1111_0000))) begin
         failures++;
         $display("FAIL event: got id=%0d resp_ev=%0d val=%0h resp=%0d wdata=%0h expected id=%0d resp_ev=%0d val=%0h resp=%0d",
                  id, is_resp, val, resp, arb2dmem_wdata, e.id, e.is_resp, e.val, e.resp);
      end
      if (is_resp) last_resp_cyc = cyc;
      else if (e.b2b) chk("ack_next_cycle_after_resp", 64'(cyc), 64'(last_resp_cyc + 1));
   endtask
   always @(negedge clk) if (rst_n) begin
      if (arb2lsu_req_ack) check_ev(SCR1_ARB_ID_LSU, 1'b0, arb2dmem_addr, SCR1_MEM_RESP_NOTRDY);
      if (arb2vexu_req_ack) check_ev(SCR1_ARB_ID_VEXU, 1'b0, arb2dmem_addr, SCR1_MEM_RESP_NOTRDY);
      if (arb2lsu_resp != SCR1_MEM_RESP_NOTRDY) begin
         check_ev(SCR1_ARB_ID_LSU, 1'b1, arb2lsu_rdata, arb2lsu_resp);
         chk("vexu_idle_during_lsu_resp", {30'd0, arb2vexu_resp, arb2vexu_rdata}, 64'd0);
      end
      if (arb2vexu_resp != SCR1_MEM_RESP_NOTRDY) begin
         check_ev(SCR1_ARB_ID_VEXU, 1'b1, arb2vexu_rdata, arb2vexu_resp);
         chk("lsu_idle_during_vexu_resp", {30'd0, arb2lsu_resp, arb2lsu_rdata}, 64'd0);
      end
   end
   function automatic void exp_txn(input type_scr1_arb_id_e id, input logic [31:0] a, input bit b2b);
      exp_q.push_back('{id, 1'b0, a, SCR1_MEM_RESP_NOTRDY, b2b});
      exp_q.push_back('{id, 1'b1, (a == 32'h100) ? 32'hDEADBEEF : ~a,
                        (a == 32'h204) ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK, 1'b0});
   endfunction
   task automatic requester(input bit v, input int n, input logic [31:0] base);
      for (int i = 0; i < n; i++) begin
         logic [31:0] a;
         type_scr1_mem_cmd_e c;
         bit got;
         int w;
         a   = base + 32'(4 * i);
         c   = (a == 32'h204) ? SCR1_MEM_CMD_WR : SCR1_MEM_CMD_RD;
         got = 1'b0;
         w   = 0;
         if (v) begin
            vexu2arb_req = 1'b1; vexu2arb_addr = a; vexu2arb_wdata = a ^ 32'h1111_0000; vexu2arb_cmd = c;
         end else begin
            lsu2arb_req = 1'b1; lsu2arb_addr = a; lsu2arb_wdata = a ^ 32'h1111_0000; lsu2arb_cmd = c;
         end
         while (!got && w < 300) begin
            @(negedge clk);
            got = v ? arb2vexu_req_ack : arb2lsu_req_ack;
            w++;
         end
         if (!got) chk("req_ack_timeout", 64'(a), 64'hFFFF_FFFF_FFFF_FFFF);
         @(posedge clk);
         #1;
      end
      if (v) vexu2arb_req = 1'b0;
      else lsu2arb_req = 1'b0;
   endtask
   task automatic drain(input string nm);
      int w = 0;
      while (exp_q.size() != 0 && w < 300) begin
         @(negedge clk);
         w++;
      end
      chk({nm, "_pending_events"}, 64'(exp_q.size()), 64'd0);
      repeat (2) @(posedge clk);
      #1;
   endtask
   task automatic chk_reset_outputs();
      chk("rst_dmem_req", 64'(arb2dmem_req), 64'd0);
      chk("rst_acks", {62'd0, arb2lsu_req_ack, arb2vexu_req_ack}, 64'd0);
      chk("rst_resps", {60'd0, arb2lsu_resp, arb2vexu_resp}, 64'd0);
      chk("rst_addr_wdata", {arb2dmem_addr, arb2dmem_wdata}, 64'd0);
      chk("rst_rdata", {arb2lsu_rdata, arb2vexu_rdata}, 64'd0);
   endtask
   initial begin
      lsu2arb_req = 1'b1; vexu2arb_req = 1'b1;
      lsu2arb_cmd = SCR1_MEM_CMD_RD; vexu2arb_cmd = SCR1_MEM_CMD_RD;
      lsu2arb_width = SCR1_MEM_WIDTH_WORD; vexu2arb_width = SCR1_MEM_WIDTH_WORD;
      lsu2arb_addr = 32'h77; vexu2arb_addr = 32'h78;
      lsu2arb_wdata = 32'h55; vexu2arb_wdata = 32'h66;
      repeat (2) @(negedge clk);
      chk_reset_outputs();
      @(posedge clk);
      #1;
      rst_n = 1'b1; lsu2arb_req = 1'b0; vexu2arb_req = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      // first conflict after reset: LSU then VEXU
      exp_txn(SCR1_ARB_ID_LSU, 32'h10, 1'b0);
      exp_txn(SCR1_ARB_ID_VEXU, 32'h20, 1'b1);
      fork
         requester(1'b0, 1, 32'h10);
         requester(1'b1, 1, 32'h20);
      join
      drain("conflict1");
      // LSU-only load, DEADBEEF response
      exp_txn(SCR1_ARB_ID_LSU, 32'h100, 1'b0);
      requester(1'b0, 1, 32'h100);
      drain("lsu_load");
      // second conflict: LSU was last served, so VEXU goes first
      exp_txn(SCR1_ARB_ID_VEXU, 32'h24, 1'b0);
      exp_txn(SCR1_ARB_ID_LSU, 32'h14, 1'b1);
      fork
         requester(1'b0, 1, 32'h14);
         requester(1'b1, 1, 32'h24);
      join
      drain("conflict2");
      exp_txn(SCR1_ARB_ID_VEXU, 32'h28, 1'b0);
      requester(1'b1, 1, 32'h28);
      drain("vexu_alone");
      // lock: round-robin now favours LSU, but the stalled VEXU grant must hold
      exp_txn(SCR1_ARB_ID_VEXU, 32'h30, 1'b0);
      exp_txn(SCR1_ARB_ID_LSU, 32'h34, 1'b1);
      ack_from = cyc + 4;
      fork
         requester(1'b1, 1, 32'h30);
         begin
            @(posedge clk);
            #1;
            requester(1'b0, 1, 32'h34);
         end
         repeat (4) begin
            @(negedge clk);
            chk("lock_grant_addr", 64'(arb2dmem_addr), 64'h30);
            chk("lock_lsu_ack_low", 64'(arb2lsu_req_ack), 64'd0);
         end
      join
      drain("lock");
      // error response to VEXU store, pending LSU follows immediately
      exp_txn(SCR1_ARB_ID_VEXU, 32'h204, 1'b0);
      exp_txn(SCR1_ARB_ID_LSU, 32'h40, 1'b1);
      fork
         requester(1'b1, 1, 32'h204);
         begin
            @(posedge clk);
            #1;
            requester(1'b0, 1, 32'h40);
         end
      join
      drain("err_resp");
      // reset during WAIT_RESP; the late response must be dropped
      lat = 4;
      exp_q.push_back('{SCR1_ARB_ID_LSU, 1'b0, 32'h300, SCR1_MEM_RESP_NOTRDY, 1'b0});
      requester(1'b0, 1, 32'h300);
      rst_n = 1'b0; lsu2arb_req = 1'b1; vexu2arb_req = 1'b1; lsu2arb_addr = 32'h700; vexu2arb_addr = 32'h704;
      @(negedge clk);
      chk_reset_outputs();
      @(posedge clk);
      #1;
      rst_n = 1'b1; lsu2arb_req = 1'b0; vexu2arb_req = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      lat = 1;
      exp_txn(SCR1_ARB_ID_VEXU, 32'h50, 1'b0);
      requester(1'b1, 1, 32'h50);
      drain("after_reset");
      // continuous requests from both: strict alternation starting with LSU
      for (int i = 0; i < 10; i++) begin
         exp_txn(SCR1_ARB_ID_LSU, 32'h1000 + 32'(4 * i), i > 0);
         exp_txn(SCR1_ARB_ID_VEXU, 32'h2000 + 32'(4 * i), 1'b1);
      end
      fork
         requester(1'b0, 10, 32'h1000);
         requester(1'b1, 10, 32'h2000);
      join
      drain("alternation");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
